// File: rtl/puzzle_backtrack_solver.sv
// puzzle_backtrack_solver
// Depth-first backtracking Sudoku-style solver over an S x S grid (S = BOX*BOX).
// Cells are walked in index order (idx = row*S + col). A non-fixed cell is given
// candidates 1..S in ascending order. Each candidate is checked against its row,
// column and box peers one k per cycle. On exhaustion the solver backtracks to the
// previous non-fixed cell. The first consistent completion found ends in DONE.
// Exhausting cell 0 ends in FAIL.
//
// Ports
//   Clk, Reset                 single clock, synchronous active-high reset
//   LoadValid/LoadRow/LoadCol/LoadValue  cell write in IDLE (value 0 = blank)
//   ClearGrid                  zero the whole grid in IDLE (beats LoadValid)
//   Start                      begin a solve from IDLE
//   StepEn                     advance the search one step per cycle when high
//   Abort                      leave any busy state for IDLE (beats StepEn)
//   Ack                        acknowledge DONE/FAIL, return to IDLE
//   RdRow/RdCol -> RdValue/RdFixed  combinational read port
//   Busy/Done/Fail/LoadErr/State/Cycles  status
//
// Control protocol: all commands are level strobes sampled on the rising edge of
// Clk. There is no ready signal. A command is accepted only in the state that
// honours it (loads/clear/start in IDLE, Abort in busy states, Ack in DONE/FAIL).
// It is silently ignored elsewhere. In IDLE, ClearGrid beats LoadValid, and
// LoadValid beats Start.
module puzzle_backtrack_solver #(
  parameter int BOX = 3,
  localparam int S  = BOX * BOX,
  localparam int IW = $clog2(S),
  localparam int VW = $clog2(S + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadValid,
  input  logic [IW-1:0] LoadRow,
  input  logic [IW-1:0] LoadCol,
  input  logic [VW-1:0] LoadValue,
  input  logic          ClearGrid,
  input  logic          Start,
  input  logic          StepEn,
  input  logic          Abort,
  input  logic          Ack,
  input  logic [IW-1:0] RdRow,
  input  logic [IW-1:0] RdCol,
  output logic [VW-1:0] RdValue,
  output logic          RdFixed,
  output logic          Busy,
  output logic          Done,
  output logic          Fail,
  output logic          LoadErr,
  output logic [2:0]    State,
  output logic [31:0]   Cycles
);

  localparam int N  = S * S;
  localparam int CW = $clog2(N);      // cell address width
  localparam int XW = $clog2(N + 1);  // idx must also reach N (end of grid)

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FORWARD = 3'd1,
    CHECK   = 3'd2,
    BACK    = 3'd3,
    RETRY   = 3'd4,
    DONE    = 3'd5,
    FAIL    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] idx_q, idx_d;
  logic [IW-1:0] k_q, k_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          loaderr_q, loaderr_d;

  logic [VW-1:0] val_q [N];
  logic          fix_q [N];

  // Grid write controls produced by the FSM
  logic          clear_all, start_clr, load_we, cell_we;
  logic [VW-1:0] cell_wval;

  // Current cell. idx == N is only ever looked at to detect completion,
  // so the address is clamped to keep the array access in range.
  logic [CW-1:0] cidx;
  logic [VW-1:0] cur_val;
  logic          cur_fix;

  assign cidx    = (idx_q < XW'(N)) ? idx_q[CW-1:0] : '0;
  assign cur_val = val_q[cidx];
  assign cur_fix = fix_q[cidx];

  // Peer addresses for this CHECK cycle: row peer (r,k), column peer (k,c)
  // and the k-th cell of the box containing (r,c).
  int            cur_r, cur_c, kk;
  logic [CW-1:0] p_row, p_col, p_box;
  logic          conflict;

  always_comb begin
    cur_r = int'(cidx) / S;
    cur_c = int'(cidx) % S;
    kk    = int'(k_q);
    p_row = CW'(cur_r * S + kk);
    p_col = CW'(kk * S + cur_c);
    p_box = CW'(((cur_r / BOX) * BOX + kk / BOX) * S + (cur_c / BOX) * BOX + kk % BOX);
    conflict = ((p_row != cidx) && (val_q[p_row] == cur_val)) ||
               ((p_col != cidx) && (val_q[p_col] == cur_val)) ||
               ((p_box != cidx) && (val_q[p_box] == cur_val));
  end

  // Load address decode; rows/cols beyond the grid are dropped.
  logic          ld_ok;
  logic [CW-1:0] ldx;
  assign ld_ok = (int'(LoadRow) < S) && (int'(LoadCol) < S);
  assign ldx   = CW'(int'(LoadRow) * S + int'(LoadCol));

  // Read port
  logic          rd_ok;
  logic [CW-1:0] rdx;
  assign rd_ok   = (int'(RdRow) < S) && (int'(RdCol) < S);
  assign rdx     = CW'(int'(RdRow) * S + int'(RdCol));
  assign RdValue = rd_ok ? val_q[rdx] : '0;
  assign RdFixed = rd_ok ? fix_q[rdx] : 1'b0;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    cycles_d  = cycles_q;
    loaderr_d = 1'b0;
    clear_all = 1'b0;
    start_clr = 1'b0;
    load_we   = 1'b0;
    cell_we   = 1'b0;
    cell_wval = '0;

    case (state_q)
      IDLE: begin
        if (ClearGrid) begin
          clear_all = 1'b1;
        end else if (LoadValid) begin
          if (LoadValue > VW'(S)) loaderr_d = 1'b1;
          else                    load_we   = ld_ok;
        end else if (Start) begin
          start_clr = 1'b1;
          idx_d     = '0;
          cycles_d  = '0;
          state_d   = FORWARD;
        end
      end

      DONE, FAIL: begin
        if (Ack) state_d = IDLE;
      end

      default: begin  // FORWARD, CHECK, BACK, RETRY
        if (Abort) begin
          state_d = IDLE;
        end else if (StepEn) begin
          cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
          case (state_q)
            FORWARD: begin
              if (idx_q == XW'(N)) begin
                state_d = DONE;
              end else if (cur_fix) begin
                idx_d = idx_q + XW'(1);
              end else begin
                cell_we   = 1'b1;
                cell_wval = VW'(1);
                k_d       = '0;
                state_d   = CHECK;
              end
            end
            CHECK: begin
              if (conflict) begin
                cell_we = 1'b1;
                if (cur_val < VW'(S)) begin
                  cell_wval = cur_val + VW'(1);
                  k_d       = '0;
                end else begin
                  cell_wval = '0;
                  state_d   = BACK;
                end
              end else if (k_q == IW'(S - 1)) begin
                idx_d   = idx_q + XW'(1);
                state_d = FORWARD;
              end else begin
                k_d = k_q + IW'(1);
              end
            end
            BACK: begin
              if (idx_q == '0) begin
                state_d = FAIL;
              end else begin
                idx_d   = idx_q - XW'(1);
                state_d = RETRY;
              end
            end
            RETRY: begin
              if (cur_fix) begin
                state_d = BACK;
              end else if (cur_val == VW'(S)) begin
                cell_we   = 1'b1;
                cell_wval = '0;
                state_d   = BACK;
              end else begin
                cell_we   = 1'b1;
                cell_wval = cur_val + VW'(1);
                k_d       = '0;
                state_d   = CHECK;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      k_q       <= '0;
      cycles_q  <= '0;
      loaderr_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        val_q[i] <= '0;
        fix_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      cycles_q  <= cycles_d;
      loaderr_q <= loaderr_d;
      if (clear_all) begin
        for (int i = 0; i < N; i++) begin
          val_q[i] <= '0;
          fix_q[i] <= 1'b0;
        end
      end else if (start_clr) begin
        for (int i = 0; i < N; i++) begin
          if (!fix_q[i]) val_q[i] <= '0;
        end
      end else if (load_we) begin
        val_q[ldx] <= LoadValue;
        fix_q[ldx] <= (LoadValue != '0);
      end else if (cell_we) begin
        val_q[cidx] <= cell_wval;
      end
    end
  end

  assign State   = state_q;
  assign Busy    = (state_q == FORWARD) || (state_q == CHECK) ||
                   (state_q == BACK)    || (state_q == RETRY);
  assign Done    = (state_q == DONE);
  assign Fail    = (state_q == FAIL);
  assign LoadErr = loaderr_q;
  assign Cycles  = cycles_q;

endmodule

// File: tb/tb_puzzle_backtrack_solver.sv
// tb_puzzle_backtrack_solver
// Directed and randomized checks of puzzle_backtrack_solver with BOX=2 (4x4 grid).
// The reference solver is a plain depth-first search over an int array. A cell
// accepts a value when no other cell in its row, column or box holds it. Givens
// are never tested against each other.
module tb_puzzle_backtrack_solver;

  localparam int BOX = 2;
  localparam int S   = 4;
  localparam int N   = 16;
  localparam int IW  = 2;
  localparam int VW  = 3;
  localparam int WAIT_MAX = 30000;

  logic          Clk = 1'b0;
  logic          Reset, LoadValid, ClearGrid, Start, StepEn, Abort, Ack;
  logic [IW-1:0] LoadRow, LoadCol, RdRow, RdCol;
  logic [VW-1:0] LoadValue, RdValue;
  logic          RdFixed, Busy, Done, Fail, LoadErr;
  logic [2:0]    State;
  logic [31:0]   Cycles;

  puzzle_backtrack_solver #(.BOX(BOX)) dut (
    .Clk(Clk), .Reset(Reset), .LoadValid(LoadValid), .LoadRow(LoadRow),
    .LoadCol(LoadCol), .LoadValue(LoadValue), .ClearGrid(ClearGrid),
    .Start(Start), .StepEn(StepEn), .Abort(Abort), .Ack(Ack),
    .RdRow(RdRow), .RdCol(RdCol), .RdValue(RdValue), .RdFixed(RdFixed),
    .Busy(Busy), .Done(Done), .Fail(Fail), .LoadErr(LoadErr),
    .State(State), .Cycles(Cycles)
  );

  // Clock
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: givens, reference grid, expected outcome
  int giv [N];
  int m_g [N];
  bit m_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int r, input int c, input int v);
    LoadValid = 1'b1;
    LoadRow   = IW'(r);
    LoadCol   = IW'(c);
    LoadValue = VW'(v);
    tick();
    LoadValid = 1'b0;
  endtask

  task automatic clear_grid();
    ClearGrid = 1'b1;
    tick();
    ClearGrid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  task automatic rd(input int r, input int c, output int v, output int f);
    RdRow = IW'(r);
    RdCol = IW'(c);
    #1;
    v = int'(RdValue);
    f = int'(RdFixed);
  endtask

  // Reference model
  function automatic bit cand_ok(input int i, input int v);
    int ri, ci, rj, cj;
    ri = i / S;
    ci = i % S;
    for (int j = 0; j < N; j++) begin
      rj = j / S;
      cj = j % S;
      if (j != i && m_g[j] == v &&
          (ri == rj || ci == cj || (ri / BOX == rj / BOX && ci / BOX == cj / BOX)))
        return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_run();
    int i, v;
    bit fin;
    for (int j = 0; j < N; j++) m_g[j] = giv[j];
    i = 0;
    fin = 1'b0;
    m_ok = 1'b0;
    while (!fin) begin
      if (i == N) begin
        m_ok = 1'b1;
        fin = 1'b1;
      end else if (giv[i] != 0) begin
        i++;
      end else begin
        v = m_g[i] + 1;
        while (v <= S && !cand_ok(i, v)) v++;
        if (v <= S) begin
          m_g[i] = v;
          i++;
        end else begin
          m_g[i] = 0;
          i--;
          while (i >= 0 && giv[i] != 0) i--;
          if (i < 0) fin = 1'b1;
        end
      end
    end
  endtask

  // Load givens, solve (with StepEn randomly dropping), compare against the model.
  task automatic solve_check(input string tag, input bit rnd_step);
    int n, v, f;
    clear_grid();
    for (int i = 0; i < N; i++)
      if (giv[i] != 0) load(i / S, i % S, giv[i]);
    model_run();
    StepEn = 1'b1;
    pulse_start();
    n = 0;
    while (!(Done || Fail) && n < WAIT_MAX) begin
      StepEn = rnd_step ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    StepEn = 1'b0;
    chk({tag, "_bound"}, 32'(n < WAIT_MAX), 32'd1);
    chk({tag, "_done"}, 32'(Done), 32'(m_ok));
    chk({tag, "_fail"}, 32'(Fail), 32'(!m_ok));
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    for (int i = 0; i < N; i++) begin
      rd(i / S, i % S, v, f);
      chk($sformatf("%s_val%0d", tag, i), 32'(v), 32'(m_g[i]));
      chk($sformatf("%s_fix%0d", tag, i), 32'(f), 32'(giv[i] != 0));
    end
    pulse_ack();
    chk({tag, "_ack_state"}, 32'(State), 32'd0);
    chk({tag, "_ack_flags"}, 32'({Done, Fail}), 32'd0);
  endtask

  int exp_empty [N] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};

  initial begin
    int v, f, n, cnt;
    Reset = 1'b1; LoadValid = 1'b0; ClearGrid = 1'b0; Start = 1'b0;
    StepEn = 1'b0; Abort = 1'b0; Ack = 1'b0;
    LoadRow = '0; LoadCol = '0; LoadValue = '0; RdRow = '0; RdCol = '0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_flags", 32'({Busy, Done, Fail, LoadErr}), 32'd0);
    chk("rst_cycles", Cycles, 32'd0);
    for (int i = 0; i < N; i++) begin
      rd(i / S, i % S, v, f);
      chk($sformatf("rst_cell%0d", i), 32'({v[3:0], f[3:0]}), 32'd0);
    end

    // Empty grid solve, compared with the known first solution
    for (int i = 0; i < N; i++) giv[i] = 0;
    solve_check("empty", 1'b0);
    for (int i = 0; i < N; i++) begin
      rd(i / S, i % S, v, f);
      chk($sformatf("empty_kept%0d", i), 32'(v), 32'(exp_empty[i]));
    end

    // Out-of-range load, then a good load and a blanking load
    clear_grid();
    load(1, 1, 5);
    chk("lderr_pulse", 32'(LoadErr), 32'd1);
    tick();
    chk("lderr_drop", 32'(LoadErr), 32'd0);
    rd(1, 1, v, f);
    chk("lderr_val", 32'(v), 32'd0);
    chk("lderr_fix", 32'(f), 32'd0);
    load(2, 3, 4);
    chk("ldok_noerr", 32'(LoadErr), 32'd0);
    rd(2, 3, v, f);
    chk("ldok_val", 32'(v), 32'd4);
    chk("ldok_fix", 32'(f), 32'd1);
    load(2, 3, 0);
    rd(2, 3, v, f);
    chk("ldblank_val", 32'(v), 32'd0);
    chk("ldblank_fix", 32'(f), 32'd0);

    // Conflicting givens exhaust the search
    for (int i = 0; i < N; i++) giv[i] = 0;
    giv[0] = 1;
    giv[1] = 1;
    solve_check("conflict", 1'b0);
    chk("conflict_model", 32'(m_ok), 32'd0);

    // Single step hold and abort. Hand trace on the empty grid after 10 steps:
    // cell 0 placed as 1; cell 1 rejected 1, now holds 2 mid-check (CHECK).
    clear_grid();
    StepEn = 1'b1;
    pulse_start();
    repeat (10) tick();
    StepEn = 1'b0;
    chk("step_cycles", Cycles, 32'd10);
    chk("step_state", 32'(State), 32'd2);
    repeat (5) tick();
    chk("hold_cycles", Cycles, 32'd10);
    chk("hold_state", 32'(State), 32'd2);
    chk("hold_busy", 32'(Busy), 32'd1);
    Abort = 1'b1;
    StepEn = 1'b1;
    tick();
    Abort = 1'b0;
    StepEn = 1'b0;
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    rd(0, 0, v, f);
    chk("abort_c0", 32'(v), 32'd1);
    rd(0, 1, v, f);
    chk("abort_c1", 32'(v), 32'd2);

    // Reset in the middle of a solve
    clear_grid();
    load(2, 2, 3);
    StepEn = 1'b1;
    pulse_start();
    n = 0;
    while (State !== 3'd2 && n < 100) begin
      tick();
      n++;
    end
    chk("midrst_reach", 32'(n < 100), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    StepEn = 1'b0;
    chk("midrst_state", 32'(State), 32'd0);
    chk("midrst_cycles", Cycles, 32'd0);
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      rd(i / S, i % S, v, f);
      if (v != 0 || f != 0) cnt++;
    end
    chk("midrst_grid_nonzero", 32'(cnt), 32'd0);

    // Randomized givens with random stepping
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) giv[i] = 0;
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++)
        giv[$urandom_range(0, N - 1)] = $urandom_range(1, S);
      solve_check($sformatf("rnd%0d", t), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puzzle_backtrack_solver.md
PUZZLE_BACKTRACK_SOLVER -- requirements
Module: puzzle_backtrack_solver

Interface
REQ-001 SHALL have parameter BOX, default 3, sub-box edge; legal range 2..4.
REQ-002 SHALL derive S = BOX*BOX (grid edge), IW = clog2(S) (row/col width), VW = clog2(S+1) (value width); derived values are not overridable.
REQ-003 SHALL have ports: Clk input 1, the single clock; Reset input 1, the reset, synchronous and active-high.
REQ-004 SHALL have LoadValid input 1 (write strobe), LoadRow input IW, LoadCol input IW, LoadValue input VW (0 = blank).
REQ-005 SHALL have ClearGrid input 1, Start input 1, StepEn input 1 (single-step enable), Abort input 1 and Ack input 1.
REQ-006 SHALL have RdRow input IW, RdCol input IW, RdValue output VW and RdFixed output 1, forming a combinational read port.
REQ-007 SHALL have Busy output 1, Done output 1, Fail output 1, LoadErr output 1, State output 3 and Cycles output 32.

Function
REQ-008 SHALL store S*S cells, each holding a VW-bit value plus a fixed bit, indexed idx = row*S + col.
REQ-009 SHALL use States IDLE=0, FORWARD=1, CHECK=2, BACK=3, RETRY=4, DONE=5, FAIL=6, driven on State.
REQ-010 SHALL drive Busy=1 in FORWARD/CHECK/BACK/RETRY, Done=1 in DONE and Fail=1 in FAIL.
REQ-011 SHALL act on LoadValid only in IDLE: write value, set fixed = (LoadValue != 0).
REQ-012 SHALL ignore a load with LoadValue > S, leave the cell unchanged and pulse LoadErr for exactly one cycle.
REQ-013 SHALL, on ClearGrid in IDLE, zero all values and fixed bits in one cycle; ClearGrid has priority over LoadValid.
REQ-014 SHALL, on Start in IDLE, zero every non-fixed cell, set idx=0, clear Cycles and enter FORWARD; Start is ignored in other states.
REQ-015 SHALL, in FORWARD: idx == S*S -> DONE; fixed cell -> idx+1, stay FORWARD; else cell=1, k=0 -> CHECK.
REQ-016 SHALL, per CHECK cycle, compare the candidate against three peers: (row, k), (k, col) and box cell k; a peer equal to the current cell is skipped.
REQ-017 SHALL, on any match (conflict) in CHECK: candidate < S -> candidate+1, k=0, stay CHECK; candidate == S -> cell=0 -> BACK.
REQ-018 SHALL, on no conflict with k == S-1, set idx+1 -> FORWARD; otherwise k+1.
REQ-019 SHALL, in BACK: idx == 0 -> FAIL; else idx-1 -> RETRY.
REQ-020 SHALL, in RETRY: fixed -> BACK; value == S -> cell=0 -> BACK; else value+1, k=0 -> CHECK.
REQ-021 SHALL hold all state, idx, k, cells and Cycles while StepEn=0 in Busy states.
REQ-022 SHALL increment Cycles on each Busy cycle with StepEn=1, saturating at 2^32-1.
REQ-023 SHALL, on Abort in any Busy state, go to IDLE next cycle with grid contents retained; Abort has priority over StepEn.
REQ-024 SHALL, on Ack in DONE or FAIL, go to IDLE with grid retained; Done/Fail stay high until Ack or Reset.
REQ-025 SHALL treat inconsistent givens as needing no special detection: exhaustion leads to FAIL.
REQ-026 SHALL return 0 on RdValue and RdFixed for RdRow or RdCol >= S.

Reset
REQ-027 SHALL, on Reset sampled high at a Clk edge, put State=IDLE, all cells value 0 and fixed 0, idx=0, k=0, Cycles=0, Busy=Done=Fail=LoadErr=0.
REQ-028 SHALL let Reset override every other input, including mid-solve.

Verification (BOX=2)
REQ-029 SHALL cover reset: Reset pulse -> State=0, every RdValue=0, all flags 0.
REQ-030 SHALL cover an empty-grid solve: empty grid, Start, StepEn=1 -> Done; rows read 1234 / 3412 / 2143 / 4321; RdFixed=0 everywhere.
REQ-031 SHALL cover conflicting givens: load (0,0)=1 and (0,1)=1, Start -> Fail=1; Ack -> IDLE; givens unchanged.
REQ-032 SHALL cover an out-of-range load: LoadValue=5 at (1,1) -> LoadErr=1 for one cycle; RdValue(1,1) stays 0.
REQ-033 SHALL cover stepping and abort: StepEn=0 after 10 Busy cycles -> Cycles holds 10 and State holds; Abort -> IDLE next cycle.
REQ-034 SHALL cover reset mid-solve: Reset asserted during CHECK -> all cells 0, State=IDLE the next cycle.
